// File: rtl/ram_s_ctrl_pkg.sv
// Shared constants, state codes and small helpers for the RAM_S controller.
package ram_s_ctrl_pkg;

    localparam int RAM_S_ADDR_WIDTH = 6;
    localparam int RAM_S_DATA_WIDTH = 16;
    localparam int RAM_S_MEM_SIZE   = 64;
    localparam int RAM_S_LOCK_MAX   = 8;

    typedef enum logic {
        RAM_S_CTL_IDLE  = 1'b0,
        RAM_S_CTL_CLEAR = 1'b1
    } ram_s_ctl_e;

    // One-hot two-bit vector selecting requester idx.
    function automatic logic [1:0] req_onehot(input logic idx);
        logic [1:0] vec;
        if (idx) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/ram_s_ctrl_rr_arb2.sv
// Two-way round-robin arbiter with burst locking and a bounded lock length.
module rr_arb2
    import ram_s_ctrl_pkg::*;
#(
    parameter int LOCK_MAX = RAM_S_LOCK_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] valid,
    input  logic [1:0] lock,
    output logic [1:0] grant
);

    localparam int                CNT_W      = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0]  LOCK_LIMIT = CNT_W'(LOCK_MAX);

    logic             rr_ptr_r;
    logic             lock_act_r;
    logic             lock_id_r;
    logic [CNT_W-1:0] lock_cnt_r;

    logic             gnt_id_s;
    logic             locked_s;
    logic             other_s;
    logic             issue_s;
    logic [1:0]       grant_s;

    // Pick the winner: an active lock beats round-robin until it hits its limit.
    always_comb begin
        gnt_id_s = 1'b0;
        locked_s = 1'b0;
        other_s  = ~lock_id_r;
        if (lock_act_r && valid[lock_id_r]) begin
            if ((lock_cnt_r == LOCK_LIMIT) && valid[other_s]) begin
                gnt_id_s = other_s;
            end else begin
                gnt_id_s = lock_id_r;
                locked_s = 1'b1;
            end
        end else if (valid == 2'b11) begin
            gnt_id_s = rr_ptr_r;
        end else begin
            gnt_id_s = valid[1] & ~valid[0];
        end
    end

    // Gate the grant with the enable and with any request being present.
    always_comb begin
        grant_s = 2'b00;
        if (enable && (valid != 2'b00)) begin
            grant_s = req_onehot(gnt_id_s);
        end else begin
            grant_s = 2'b00;
        end
    end

    assign issue_s = |grant_s;
    assign grant   = grant_s;

    // Pointer and lock bookkeeping; a locked grant does not move the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r   <= 1'b0;
            lock_act_r <= 1'b0;
            lock_id_r  <= 1'b0;
            lock_cnt_r <= {CNT_W{1'b0}};
        end else if (issue_s) begin
            if (!locked_s) begin
                rr_ptr_r <= ~gnt_id_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            lock_act_r <= lock[gnt_id_s];
            lock_id_r  <= gnt_id_s;
            if (locked_s && lock[gnt_id_s]) begin
                if (lock_cnt_r == LOCK_LIMIT) begin
                    lock_cnt_r <= lock_cnt_r;
                end else begin
                    lock_cnt_r <= lock_cnt_r + CNT_W'(1);
                end
            end else begin
                lock_cnt_r <= {CNT_W{1'b0}};
            end
        end else begin
            lock_act_r <= 1'b0;
            lock_cnt_r <= {CNT_W{1'b0}};
        end
    end

endmodule

// File: rtl/ram_s_ctrl.sv
// RAM_S port controller: two-requester arbitration, read tracking and a
// zero-fill sequencer driving the single-port SRAM pins.
module ram_s_ctrl
    import ram_s_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_S_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_S_DATA_WIDTH,
    parameter int MEM_SIZE   = RAM_S_MEM_SIZE,
    parameter int LOCK_MAX   = RAM_S_LOCK_MAX
) (
    input  logic                  CK,
    input  logic                  RST_N,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_we,
    input  logic [1:0]            req_lock,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [DATA_WIDTH-1:0] ram_d,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_SIZE - 1);

    ram_s_ctl_e            state_r;
    logic [ADDR_WIDTH-1:0] clr_cnt_r;
    logic                  clr_done_r;
    logic                  rd_pend_r;
    logic                  rd_tag_r;
    logic [ADDR_WIDTH-1:0] ram_a_last_r;

    logic                  arb_en_s;
    logic [1:0]            grant_s;
    logic                  issue_s;
    logic                  gnt_id_s;
    logic [ADDR_WIDTH-1:0] mux_a_s;
    logic                  mux_we_s;
    logic [DATA_WIDTH-1:0] mux_d_s;

    assign arb_en_s = (state_r == RAM_S_CTL_IDLE);
    assign issue_s  = |grant_s;
    assign gnt_id_s = grant_s[1];

    rr_arb2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk    (CK),
        .rst_n  (RST_N),
        .enable (arb_en_s),
        .valid  (req_valid),
        .lock   (req_lock),
        .grant  (grant_s)
    );

    // RAM pin mux: clear sequencer, granted request, or hold address when idle.
    always_comb begin
        mux_a_s  = ram_a_last_r;
        mux_we_s = 1'b0;
        mux_d_s  = {DATA_WIDTH{1'b0}};
        if (state_r == RAM_S_CTL_CLEAR) begin
            mux_a_s  = clr_cnt_r;
            mux_we_s = 1'b1;
        end else if (issue_s) begin
            mux_a_s  = gnt_id_s ? req_addr1 : req_addr0;
            mux_we_s = req_we[gnt_id_s];
            if (req_we[gnt_id_s]) begin
                mux_d_s = gnt_id_s ? req_wdata1 : req_wdata0;
            end else begin
                mux_d_s = {DATA_WIDTH{1'b0}};
            end
        end else begin
            mux_a_s = ram_a_last_r;
        end
    end

    // Output stage; everything reads as its reset value while RST_N is low.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        rsp_rdata = {DATA_WIDTH{1'b0}};
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        ram_a     = {ADDR_WIDTH{1'b0}};
        ram_we    = 1'b0;
        ram_oe    = 1'b0;
        ram_d     = {DATA_WIDTH{1'b0}};
        if (RST_N) begin
            req_ready = grant_s;
            if (rd_pend_r) begin
                rsp_valid = req_onehot(rd_tag_r);
                rsp_rdata = ram_q;
            end else begin
                rsp_valid = 2'b00;
                rsp_rdata = {DATA_WIDTH{1'b0}};
            end
            clr_busy = (state_r == RAM_S_CTL_CLEAR);
            clr_done = clr_done_r;
            ram_a    = mux_a_s;
            ram_we   = mux_we_s;
            ram_oe   = rd_pend_r;
            ram_d    = mux_d_s;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Controller FSM and clear counter.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= RAM_S_CTL_IDLE;
            clr_cnt_r  <= {ADDR_WIDTH{1'b0}};
            clr_done_r <= 1'b0;
        end else begin
            case (state_r)
                RAM_S_CTL_IDLE: begin
                    clr_done_r <= 1'b0;
                    if (clr_start) begin
                        state_r   <= RAM_S_CTL_CLEAR;
                        clr_cnt_r <= {ADDR_WIDTH{1'b0}};
                    end else begin
                        state_r   <= RAM_S_CTL_IDLE;
                    end
                end
                RAM_S_CTL_CLEAR: begin
                    if (clr_cnt_r == LAST_IDX) begin
                        state_r    <= RAM_S_CTL_IDLE;
                        clr_cnt_r  <= {ADDR_WIDTH{1'b0}};
                        clr_done_r <= 1'b1;
                    end else begin
                        clr_cnt_r  <= clr_cnt_r + ADDR_WIDTH'(1);
                        clr_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= RAM_S_CTL_IDLE;
                    clr_cnt_r  <= {ADDR_WIDTH{1'b0}};
                    clr_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Read tracking: the response slot is the cycle after a read is issued.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            rd_pend_r    <= 1'b0;
            rd_tag_r     <= 1'b0;
            ram_a_last_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            rd_pend_r    <= issue_s & ~req_we[gnt_id_s];
            rd_tag_r     <= gnt_id_s;
            ram_a_last_r <= mux_a_s;
        end
    end

endmodule

// File: doc/ram_s_ctrl.md
# ram_s_ctrl

Controller and arbiter for the single-port scratch SRAM RAM_S in the OMP datapath. It lets two requesters share the port: requester 0 is the correlation engine and requester 1 is the least-squares update. Arbitration is round-robin, with optional burst locking. It also contains a built-in clear sequencer that zero-fills the whole memory between OMP iterations. It drives the RAM's A/WE/OE/D pins and returns read data from Q.

## Interface
- ADDR_WIDTH, default `RAM_S_ADDR_WIDTH: RAM address width
- DATA_WIDTH, default `RAM_S_DATA_WIDTH: RAM data width
- MEM_SIZE, default `RAM_S_MEM_SIZE: number of words cleared by the sequencer
- LOCK_MAX, default 8: maximum consecutive locked grants before forced release
- Clock and reset: one clock; reset is asynchronous and active-low.
- CK, in, 1: clock, shared with RAM_S
- RST_N, in, 1: asynchronous active-low reset
- req_valid[1:0], in, 2: access request per requester
- req_we[1:0], in, 2: 1 = write, 0 = read
- req_lock[1:0], in, 2: hold the grant for the next cycle (burst)
- req_addr0, req_addr1, in, ADDR_WIDTH: address per requester
- req_wdata0, req_wdata1, in, DATA_WIDTH: write data per requester
- req_ready[1:0], out, 2: grant; an access is issued when valid & ready
- rsp_valid[1:0], out, 2: read data valid for the requester
- rsp_rdata, out, DATA_WIDTH: read data, shared by both requesters and qualified by rsp_valid
- clr_start, in, 1: pulse that starts a zero-fill
- clr_busy, out, 1: clear in progress
- clr_done, out, 1: one-cycle pulse when the clear completes
- ram_a, out, ADDR_WIDTH: to RAM_S A
- ram_we, out, 1: to RAM_S WE
- ram_oe, out, 1: to RAM_S OE
- ram_d, out, DATA_WIDTH: to RAM_S D
- ram_q, in, DATA_WIDTH: from RAM_S Q

## Operation
- **States:** IDLE (arbitrating) and CLEAR.
- **IDLE, single requester:** if exactly one requester is valid, it is granted.
- **IDLE, both valid:** the requester named by the round-robin pointer `rr_ptr` is granted.
- **Pointer update:** after a grant to requester i, `rr_ptr` becomes 1-i. The exception is a locked grant, which leaves `rr_ptr` unchanged.
- **Lock:** if the granted requester has req_lock=1 at the issuing edge, it keeps priority in the next cycle while it stays valid.
  - `lock_cnt` counts consecutive locked grants.
  - When `lock_cnt` reaches LOCK_MAX and the other requester is valid, the lock is dropped and the other requester is granted.
  - `lock_cnt` clears whenever the grant changes hands or lock is released.
- **Driving the RAM:** ram_a, ram_we and ram_d follow the granted request combinationally.
  - With no grant: ram_we=0, ram_a holds its last value, ram_d=0.
  - Exactly one access is issued per cycle, at most.
- **Read tracking:** a read issued at the edge ending cycle N sets the `rd_pend` and `rd_tag` registers.
  - In cycle N+1: ram_oe=1, rsp_valid[rd_tag]=1, rsp_rdata=ram_q.
  - At all other times ram_oe=0 and rsp_valid=0.
  - Back-to-back reads give one response per cycle.
- **Clear start:** clr_start=1 at an edge while in IDLE moves the block to CLEAR and sets `clr_cnt`=0. Arbitration in the cycle clr_start is asserted is unaffected.
- **CLEAR:**
  - req_ready=00.
  - ram_we=1, ram_d=0, ram_a=`clr_cnt`, clr_busy=1.
  - `clr_cnt` increments once per cycle.
  - At the edge where `clr_cnt`=MEM_SIZE-1, the block returns to IDLE and clr_done=1 for the following cycle.
- **clr_start while busy:** clr_start during CLEAR is ignored.
- **Read pending at clear start:** a read issued in the cycle clr_start is asserted still gets its response in the first CLEAR cycle.
- **Reset:** asserting RST_N low, including mid-clear or mid-burst, sends the block asynchronously to IDLE. The following are cleared:
  - `rr_ptr`=0, `lock_cnt`=0, `clr_cnt`=0, `rd_pend`=0.

## Timing
- **Reset values:** req_ready=00, rsp_valid=00, rsp_rdata=0, clr_busy=0, clr_done=0, ram_we=0, ram_oe=0, ram_a=0, ram_d=0.
  - Combinational outputs are forced to these values while RST_N=0.
- **Ready path:** req_ready is combinational from req_valid, `rr_ptr`, the lock state and the FSM state.
  - The ready path must not depend on ram_q.
- **Write latency:** the memory is updated at the issuing edge.
- **Read latency:** 1 cycle. Data appears in the cycle after issue and is valid only in that cycle; the requester must capture it.
- **Write-then-read:** a write followed by a read of the same address in the next cycle returns the new data.
- **Clear duration:** MEM_SIZE cycles of clr_busy=1, then one cycle of clr_done=1. clr_busy and clr_done never overlap.

## Structure
- **Shared constants:** `RAM_S_ADDR_WIDTH`, `RAM_S_DATA_WIDTH` and `RAM_S_MEM_SIZE` stay in define.vh.
  - Add the state codes `RAM_S_CTL_IDLE`=1'b0 and `RAM_S_CTL_CLEAR`=1'b1.
  - Add `RAM_S_LOCK_MAX` there.
- **Sub-module:** `rr_arb2` is the natural sub-module. It is a two-way round-robin and lock arbiter holding `rr_ptr` and `lock_cnt`, with inputs valid, lock and enable and output grant.
  - The top level holds the FSM, the clear counter, the read tracking and the RAM muxing.

## Test plan
- **Single write/read:** req0 writes 0x5A to addr 3, then reads addr 3 → rsp_valid[0]=1 exactly one cycle after the read grant, rsp_rdata=0x5A, ram_oe=1 only in that cycle.
- **Round-robin:** both requesters valid continuously with lock=0 → grants alternate 0,1,0,1 starting from requester 0 after reset; rsp_valid tags match the grants.
- **Lock limit:** req1 valid with lock=1, req0 valid, LOCK_MAX=8 → req1 is granted 9 consecutive cycles (the initial grant plus 8 locked grants), then req0 is granted.
- **Clear:** preload nonzero data, pulse clr_start → clr_busy for MEM_SIZE cycles with ram_a=0..MEM_SIZE-1, req_ready=00 throughout, clr_done pulses once, and all subsequent reads return 0.
- **Clear collision:** clr_start in the same cycle as a req0 read of addr 7 → the read is granted and its response arrives in the first CLEAR cycle with the old data. A second clr_start during CLEAR is ignored.
- **Reset mid-clear:** assert RST_N=0 at clr_cnt=5 → all outputs go immediately to their reset values. After release the block is in IDLE and a new request is granted in its first cycle.
